// File: rtl/mult_div_unit.sv
// Multicycle HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// One shared add/subtract stage is iterated 32 times: shift-add for multiply,
// restoring shift-subtract for divide. A FIX cycle applies signs and writes HI/LO.
// busy/done/div_by_zero are registered copies of the FSM state, so they trail it
// by one edge. start is honoured only in IDLE or DONE.
// Handshake: start is taken on an edge where the unit is not running; the result
// is valid in hi/lo/div_by_zero whenever done is high (a single-cycle pulse).
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(ITERS);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic             idle_like;
   logic             accept;

   // captured operation context
   logic             op_div;
   logic             neg_res;
   logic             sign_a;
   logic             dz_pend;
   logic [WIDTH-1:0] a_raw;
   logic [WIDTH-1:0] opb;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc;      // product high half or partial remainder
   logic [WIDTH-1:0] work_lo;  // multiplier/product low half or quotient

   logic             sa;
   logic             sb;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   logic [WIDTH-1:0]   r_sh;
   logic [WIDTH:0]     add_x;
   logic [WIDTH:0]     add_y;
   logic               add_sub;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     mul_hi;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign idle_like = (state == IDLE) || (state == DONE);
   assign accept    = start && idle_like;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (cnt == CW'(ITERS - 1)) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = accept ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // iteration counter, restarted by every accepted start
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                cnt <= '0;
      else if (accept)        cnt <= '0;
      else if (state == RUN)  cnt <= cnt + CW'(1);
   end

   // operand sign/magnitude; MULTU/DIVU (op[0]=1) use raw operands
   always_comb begin
      sa    = ~op[0] & a[WIDTH-1];
      sb    = ~op[0] & b[WIDTH-1];
      mag_a = sa ? -a : a;
      mag_b = sb ? -b : b;
   end

   // shared add/subtract stage: add for multiply, subtract for divide trial
   always_comb begin
      r_sh    = {acc[WIDTH-2:0], work_lo[WIDTH-1]};
      add_x   = {1'b0, acc};
      add_y   = {1'b0, opb};
      add_sub = 1'b0;
      if (op_div) begin
         add_x   = {1'b0, r_sh};
         add_sub = 1'b1;
      end
      add_sum = add_sub ? (add_x - add_y) : (add_x + add_y);
      mul_hi  = work_lo[0] ? add_sum : {1'b0, acc};
   end

   // FIX-cycle sign correction and divide-by-zero override
   always_comb begin
      prod     = {acc, work_lo};
      prod_fix = neg_res ? -prod : prod;
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (op_div) begin
         res_lo = neg_res ? -work_lo : work_lo;
         res_hi = sign_a ? -acc : acc;
         if (dz_pend) begin
            res_hi = a_raw;
            res_lo = '1;
         end
      end
   end

   // datapath: capture on start, one shift-add / shift-subtract per RUN cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_div  <= 1'b0;
         neg_res <= 1'b0;
         sign_a  <= 1'b0;
         dz_pend <= 1'b0;
         a_raw   <= '0;
         opb     <= '0;
         acc     <= '0;
         work_lo <= '0;
      end else if (accept) begin
         op_div  <= op[1];
         neg_res <= sa ^ sb;
         sign_a  <= sa;
         dz_pend <= op[1] && (b == '0);
         a_raw   <= a;
         opb     <= op[1] ? mag_b : mag_a;
         acc     <= '0;
         work_lo <= op[1] ? mag_a : mag_b;
      end else if (state == RUN) begin
         if (op_div) begin
            if (!add_sum[WIDTH]) begin
               acc     <= add_sum[WIDTH-1:0];
               work_lo <= {work_lo[WIDTH-2:0], 1'b1};
            end else begin
               acc     <= r_sh;
               work_lo <= {work_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc     <= mul_hi[WIDTH:1];
            work_lo <= {mul_hi[0], work_lo[WIDTH-1:1]};
         end
      end
   end

   // registered status; div_by_zero is cleared by a start from IDLE only, so a
   // start taken in DONE cannot drop it before the matching done pulse appears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         busy <= (state == RUN) || (state == FIX);
         done <= (state == DONE);
         if (state == FIX)                     div_by_zero <= dz_pend;
         else if (accept && (state == IDLE))   div_by_zero <= 1'b0;
      end
   end

   // HI/LO: result write at FIX->DONE, MTHI/MTLO only while not running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (state == FIX) begin
         hi <= res_hi;
         lo <= res_lo;
      end else if (idle_like) begin
         if (mthi) hi <= wdata;
         if (mtlo) lo <= wdata;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: HI/LO results, latency, boundaries,
// busy-time filtering, MTHI/MTLO, asynchronous reset and back-to-back ops.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   // clock
   initial forever #5 clk = ~clk;

   // launch one op, scramble the operand inputs after the start edge, and count
   // edges until done is seen (bounded)
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                  busy, done, div_by_zero, hi, lo);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_mult;
      int lat;
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      checks += 3;
      if (lat !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", lat); end
      if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
      if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat);
      checks += 3;
      if (lat !== 34) begin errors++; $display("FAIL mult_latency got %0d want 34", lat); end
      if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
      if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
      run_op(2'b00, 32'h0000_0000, 32'h1234_5678, lat);
      checks += 2;
      if (hi !== 32'h0) begin errors++; $display("FAIL mult_zero_hi got %h want 0", hi); end
      if (lo !== 32'h0) begin errors++; $display("FAIL mult_zero_lo got %h want 0", lo); end
   endtask

   task automatic test_div;
      int lat;
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat);
      checks += 4;
      if (lat !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
      if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
      if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_neg_dz got %b want 0", div_by_zero); end
      run_op(2'b11, 32'd100, 32'd7, lat);
      checks += 2;
      if (lo !== 32'h0000_000E) begin errors++; $display("FAIL divu_lo got %h want 0000000e", lo); end
      if (hi !== 32'h0000_0002) begin errors++; $display("FAIL divu_hi got %h want 00000002", hi); end
      run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, lat);
      checks += 2;
      if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdivisor_lo got %h want fffffffd", lo); end
      if (hi !== 32'h0000_0001) begin errors++; $display("FAIL div_negdivisor_hi got %h want 00000001", hi); end
   endtask

   task automatic test_boundary;
      int lat;
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      checks += 2;
      if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_minneg_lo got %h want 80000000", lo); end
      if (hi !== 32'h0) begin errors++; $display("FAIL div_minneg_hi got %h want 0", hi); end
      run_op(2'b11, 32'd5, 32'd0, lat);
      checks += 4;
      if (lat !== 34) begin errors++; $display("FAIL divzero_latency got %0d want 34", lat); end
      if (hi !== 32'd5) begin errors++; $display("FAIL divzero_hi got %h want 00000005", hi); end
      if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divzero_lo got %h want ffffffff", lo); end
      if (div_by_zero !== 1'b1) begin errors++; $display("FAIL divzero_flag got %b want 1", div_by_zero); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (div_by_zero !== 1'b1) begin errors++; $display("FAIL divzero_hold got %b want 1", div_by_zero); end
      run_op(2'b11, 32'd9, 32'd3, lat);
      checks += 2;
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divzero_clear got %b want 0", div_by_zero); end
      if (lo !== 32'd3) begin errors++; $display("FAIL divu_exact_lo got %h want 00000003", lo); end
   endtask

   task automatic test_busy_ignore;
      int lat;
      @(negedge clk);
      op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1; mthi = 1'b1; wdata = 32'h0000_ABCD;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0;
      checks++;
      if (hi !== 32'h0000_ABCD) begin errors++; $display("FAIL mthi_with_start got %h want 0000abcd", hi); end
      lat = 0;
      repeat (5) begin @(posedge clk); #1; lat++; end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_run got %b want 1", busy); end
      @(negedge clk);
      op = 2'b10; a = 32'd1; b = 32'd0; start = 1'b1; mthi = 1'b1; wdata = 32'h0000_5555;
      @(posedge clk); #1;
      lat++;
      start = 1'b0; mthi = 1'b0;
      checks++;
      if (hi !== 32'h0000_ABCD) begin errors++; $display("FAIL mthi_while_busy got %h want 0000abcd", hi); end
      while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
      checks += 4;
      if (lat !== 34) begin errors++; $display("FAIL ignore_latency got %0d want 34", lat); end
      if (hi !== 32'h0) begin errors++; $display("FAIL ignore_hi got %h want 0", hi); end
      if (lo !== 32'h0000_002A) begin errors++; $display("FAIL ignore_lo got %h want 0000002a", lo); end
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ignore_dz got %b want 0", div_by_zero); end
   endtask

   task automatic test_mtlo;
      @(negedge clk);
      mtlo = 1'b1; wdata = 32'h0000_1234;
      @(posedge clk); #1;
      mtlo = 1'b0;
      checks++;
      if (lo !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_idle got %h want 00001234", lo); end
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_CAFE;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      checks += 2;
      if (hi !== 32'h0000_CAFE) begin errors++; $display("FAIL mt_both_hi got %h want 0000cafe", hi); end
      if (lo !== 32'h0000_CAFE) begin errors++; $display("FAIL mt_both_lo got %h want 0000cafe", lo); end
   endtask

   task automatic test_reset_midrun;
      int lat;
      @(negedge clk);
      op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         errors++;
         $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
      end
      @(negedge clk) rst = 1'b0;
      run_op(2'b01, 32'd3, 32'd5, lat);
      checks += 3;
      if (lat !== 34) begin errors++; $display("FAIL post_reset_latency got %0d want 34", lat); end
      if (lo !== 32'd15) begin errors++; $display("FAIL post_reset_lo got %h want 0000000f", lo); end
      if (hi !== 32'd0) begin errors++; $display("FAIL post_reset_hi got %h want 0", hi); end
   endtask

   task automatic test_back_to_back;
      int lat;
      run_op(2'b11, 32'd100, 32'd7, lat);
      checks++;
      if (lo !== 32'h0000_000E) begin errors++; $display("FAIL b2b_first_lo got %h want 0000000e", lo); end
      // next start lands on the edge right after done rises; done must drop there
      run_op(2'b00, 32'hFFFF_FFFE, 32'd3, lat);
      checks += 3;
      if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", lat); end
      if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hi got %h want ffffffff", hi); end
      if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL b2b_lo got %h want fffffffa", lo); end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_boundary();
      test_busy_ignore();
      test_mtlo();
      test_reset_midrun();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
